// File: rtl/ahb_pkg.sv
// Shared AHB encodings and error-tracker state type.
// Consumed by the arbiter, the master mux and their benches.
`ifndef NUM_MASTERS
`define NUM_MASTERS 4
`endif

package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic {OKAY, ERR_WAIT} err_state_t;

    function automatic logic htrans_active(input logic [1:0] t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_master_mux_if.sv
// Per-master request bundle plus the shared-bus side of the master mux.
// The slave modport is the mux itself; master is the arbiter/masters side.
interface ahb_master_mux_if #(
    parameter int NUM_MASTERS = `NUM_MASTERS,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MW          = $clog2(NUM_MASTERS)
);
    logic [MW-1:0]                 Hmaster;
    logic [NUM_MASTERS-1:0]        Hgrant;
    logic [NUM_MASTERS*ADDR_W-1:0] M_Haddr;
    logic [NUM_MASTERS*2-1:0]      M_Htrans;
    logic [NUM_MASTERS-1:0]        M_Hwrite;
    logic [NUM_MASTERS*3-1:0]      M_Hsize;
    logic [NUM_MASTERS*3-1:0]      M_Hburst;
    logic [NUM_MASTERS*DATA_W-1:0] M_Hwdata;
    logic                          Hready;
    logic                          Hresp;
    logic [ADDR_W-1:0]             Haddr;
    logic [1:0]                    Htrans;
    logic                          Hwrite;
    logic [2:0]                    Hsize;
    logic [2:0]                    Hburst;
    logic [DATA_W-1:0]             Hwdata;
    logic [MW-1:0]                 Hmaster_data;
    logic                          Hcancel;
    logic [7:0]                    err_count;

    modport slave (
        input  Hmaster, Hgrant, M_Haddr, M_Htrans, M_Hwrite, M_Hsize, M_Hburst,
               M_Hwdata, Hready, Hresp,
        output Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hmaster_data,
               Hcancel, err_count
    );

    modport master (
        output Hmaster, Hgrant, M_Haddr, M_Htrans, M_Hwrite, M_Hsize, M_Hburst,
               M_Hwdata, Hready, Hresp,
        input  Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hmaster_data,
               Hcancel, err_count
    );
endinterface

// File: rtl/ahb_err_tracker.sv
// Two-cycle ERROR response tracker: cancels the next address phase while the
// response completes and keeps a saturating count of error responses.
module ahb_err_tracker
    import ahb_pkg::*;
(
    input  logic       Hclk,
    input  logic       Hresetn,
    input  logic       Hready,
    input  logic       Hresp,
    input  logic       data_valid,
    output logic       Hcancel,
    output logic [7:0] err_count
);
    err_state_t err_state, err_state_nxt;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) err_state <= OKAY;
        else          err_state <= err_state_nxt;
    end

    always_comb begin
        err_state_nxt = err_state;
        unique case (err_state)
            OKAY:
                if (Hresp == HRESP_ERROR && !Hready && data_valid)
                    err_state_nxt = ERR_WAIT;
            // Hresp dropping before Hready is a protocol violation; recover.
            ERR_WAIT:
                if (Hready || Hresp == HRESP_OKAY)
                    err_state_nxt = OKAY;
            default: err_state_nxt = OKAY;
        endcase
    end

    always_comb begin
        Hcancel = (err_state == ERR_WAIT);
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn)
            err_count <= '0;
        else if (err_state == OKAY && err_state_nxt == ERR_WAIT && err_count != '1)
            err_count <= err_count + 8'd1;
    end
endmodule

// File: rtl/ahb_master_mux.sv
// Address/control multiplexer for the granted AHB master, with data-phase
// owner tracking for Hwdata routing and error-response cancellation.
module ahb_master_mux
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = `NUM_MASTERS,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input logic              Hclk,
    input logic              Hresetn,
    ahb_master_mux_if.slave  bus
);
    logic [ADDR_W-1:0] addr_a  [NUM_MASTERS];
    logic [1:0]        trans_a [NUM_MASTERS];
    logic              write_a [NUM_MASTERS];
    logic [2:0]        size_a  [NUM_MASTERS];
    logic [2:0]        burst_a [NUM_MASTERS];
    logic [DATA_W-1:0] wdata_a [NUM_MASTERS];

    logic [MW-1:0] sel;
    logic [MW-1:0] data_master;
    logic          data_valid;
    logic          data_write;
    logic          cancel;

    always_comb begin
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            addr_a[i]  = bus.M_Haddr[i*ADDR_W +: ADDR_W];
            trans_a[i] = bus.M_Htrans[i*2 +: 2];
            write_a[i] = bus.M_Hwrite[i];
            size_a[i]  = bus.M_Hsize[i*3 +: 3];
            burst_a[i] = bus.M_Hburst[i*3 +: 3];
            wdata_a[i] = bus.M_Hwdata[i*DATA_W +: DATA_W];
        end
    end

    // Out-of-range indices fold onto master 0.
    if (NUM_MASTERS == (1 << MW)) begin : g_sel_full
        assign sel = bus.Hmaster;
    end else begin : g_sel_clamp
        assign sel = (int'(bus.Hmaster) < NUM_MASTERS) ? bus.Hmaster : '0;
    end

    always_comb begin
        bus.Haddr  = addr_a[sel];
        bus.Hwrite = write_a[sel];
        bus.Hsize  = size_a[sel];
        bus.Hburst = burst_a[sel];
        bus.Htrans = trans_a[sel];
        if (!Hresetn || !bus.Hgrant[sel] || cancel)
            bus.Htrans = HTRANS_IDLE;
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            data_master <= '0;
            data_valid  <= 1'b0;
            data_write  <= 1'b0;
        end else if (bus.Hready) begin
            data_master <= sel;
            data_valid  <= htrans_active(bus.Htrans);
            data_write  <= bus.Hwrite;
        end
    end

    always_comb begin
        bus.Hwdata       = (data_valid && data_write) ? wdata_a[data_master] : '0;
        bus.Hmaster_data = data_master;
        bus.Hcancel      = cancel;
    end

    ahb_err_tracker u_err_tracker (
        .Hclk       (Hclk),
        .Hresetn    (Hresetn),
        .Hready     (bus.Hready),
        .Hresp      (bus.Hresp),
        .data_valid (data_valid),
        .Hcancel    (cancel),
        .err_count  (bus.err_count)
    );
endmodule

// File: tb/tb_ahb_master_mux.sv
// Directed bench for ahb_master_mux: reset, pipeline, handover, grant
// mismatch, error cancellation, counter saturation and async reset.
module tb_ahb_master_mux;
    import ahb_pkg::*;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 2;

    logic Hclk = 1'b0;
    logic Hresetn;
    int   checks = 0;
    int   errors = 0;

    ahb_master_mux_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .MW(MW)) bus ();

    ahb_master_mux #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .MW(MW)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus)
    );

    always #5 Hclk = ~Hclk;

    task automatic cyc();
        @(posedge Hclk);
        #1;
    endtask

    task automatic set_m(input int i, input logic [31:0] a, input logic [1:0] t,
                         input logic w, input logic [2:0] b, input logic [31:0] d);
        bus.M_Haddr[i*AW +: AW]  = a;
        bus.M_Htrans[i*2 +: 2]   = t;
        bus.M_Hwrite[i]          = w;
        bus.M_Hsize[i*3 +: 3]    = 3'b010;
        bus.M_Hburst[i*3 +: 3]   = b;
        bus.M_Hwdata[i*DW +: DW] = d;
    endtask

    task automatic set_own(input int m);
        bus.Hmaster   = MW'(m);
        bus.Hgrant    = '0;
        bus.Hgrant[m] = 1'b1;
    endtask

    task automatic test_reset();
        Hresetn = 1'b0;
        bus.Hready = 1'b1;
        bus.Hresp  = HRESP_OKAY;
        bus.M_Haddr = '0; bus.M_Htrans = '0; bus.M_Hwrite = '0;
        bus.M_Hsize = '0; bus.M_Hburst = '0; bus.M_Hwdata = '0;
        set_own(0);
        set_m(0, 32'h1000, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 32'h0);
        #1;
        checks++; if (bus.Htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %b expected 00", bus.Htrans); end
        checks++; if (bus.Hwdata !== 32'h0) begin errors++; $display("FAIL reset_hwdata: got %h expected 0", bus.Hwdata); end
        checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt: got %0d expected 0", bus.err_count); end
        checks++; if (bus.Hcancel !== 1'b0) begin errors++; $display("FAIL reset_hcancel: got %b expected 0", bus.Hcancel); end
        checks++; if (bus.Hmaster_data !== 2'd0) begin errors++; $display("FAIL reset_hmdata: got %0d expected 0", bus.Hmaster_data); end
        cyc(); cyc();
        Hresetn = 1'b1;
        #1;
        checks++; if (bus.Haddr !== 32'h1000) begin errors++; $display("FAIL release_haddr: got %h expected 1000", bus.Haddr); end
        checks++; if (bus.Htrans !== 2'b10) begin errors++; $display("FAIL release_htrans: got %b expected 10", bus.Htrans); end
    endtask

    task automatic test_pipeline();
        set_m(0, 32'h1000, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 32'h0);
        set_own(1);
        set_m(1, 32'h2000, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE, 32'hA5A5A5A5);
        #1;
        checks++; if (bus.Haddr !== 32'h2000) begin errors++; $display("FAIL pipe_haddr: got %h expected 2000", bus.Haddr); end
        checks++; if (bus.Hwrite !== 1'b1) begin errors++; $display("FAIL pipe_hwrite: got %b expected 1", bus.Hwrite); end
        cyc();
        set_m(1, 32'h2000, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 32'hA5A5A5A5);
        bus.Hready = 1'b0;
        #1;
        checks++; if (bus.Hmaster_data !== 2'd1) begin errors++; $display("FAIL pipe_hmdata: got %0d expected 1", bus.Hmaster_data); end
        checks++; if (bus.Hwdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL pipe_hwdata: got %h expected a5a5a5a5", bus.Hwdata); end
        for (int n = 0; n < 2; n++) begin
            cyc();
            checks++; if (bus.Hwdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL pipe_wait_hwdata[%0d]: got %h expected a5a5a5a5", n, bus.Hwdata); end
        end
        bus.Hready = 1'b1;
        cyc();
        checks++; if (bus.Hwdata !== 32'h0) begin errors++; $display("FAIL pipe_idle_hwdata: got %h expected 0", bus.Hwdata); end
    endtask

    task automatic test_handover();
        set_own(0);
        set_m(0, 32'h0, HTRANS_NONSEQ, 1'b1, HBURST_INCR4, 32'h0);
        set_m(2, 32'h3000, HTRANS_IDLE, 1'b1, HBURST_SINGLE, 32'hDEAD0002);
        cyc();
        set_m(0, 32'h4, HTRANS_SEQ, 1'b1, HBURST_INCR4, 32'h100);
        #1;
        checks++; if (bus.Hmaster_data !== 2'd0) begin errors++; $display("FAIL ho_beat1_owner: got %0d expected 0", bus.Hmaster_data); end
        checks++; if (bus.Hwdata !== 32'h100) begin errors++; $display("FAIL ho_beat1_data: got %h expected 100", bus.Hwdata); end
        cyc();
        set_m(0, 32'h8, HTRANS_SEQ, 1'b1, HBURST_INCR4, 32'h104);
        cyc();
        set_m(0, 32'hC, HTRANS_SEQ, 1'b1, HBURST_INCR4, 32'h108);
        #1;
        checks++; if (bus.Hwdata !== 32'h108) begin errors++; $display("FAIL ho_beat3_data: got %h expected 108", bus.Hwdata); end
        cyc();
        set_own(2);
        set_m(2, 32'h3000, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE, 32'hDEAD0002);
        set_m(0, 32'h0, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 32'h10C);
        bus.Hready = 1'b0;
        #1;
        checks++; if (bus.Hmaster_data !== 2'd0) begin errors++; $display("FAIL ho_beat4_owner: got %0d expected 0", bus.Hmaster_data); end
        checks++; if (bus.Hwdata !== 32'h10C) begin errors++; $display("FAIL ho_beat4_data: got %h expected 10c", bus.Hwdata); end
        checks++; if (bus.Haddr !== 32'h3000) begin errors++; $display("FAIL ho_new_haddr: got %h expected 3000", bus.Haddr); end
        checks++; if (bus.Htrans !== 2'b10) begin errors++; $display("FAIL ho_new_htrans: got %b expected 10", bus.Htrans); end
        cyc();
        checks++; if (bus.Hmaster_data !== 2'd0) begin errors++; $display("FAIL ho_wait_owner: got %0d expected 0", bus.Hmaster_data); end
        checks++; if (bus.Hwdata !== 32'h10C) begin errors++; $display("FAIL ho_wait_data: got %h expected 10c", bus.Hwdata); end
        bus.Hready = 1'b1;
        cyc();
        set_m(2, 32'h3000, HTRANS_IDLE, 1'b1, HBURST_SINGLE, 32'hDEAD0002);
        #1;
        checks++; if (bus.Hmaster_data !== 2'd2) begin errors++; $display("FAIL ho_m2_owner: got %0d expected 2", bus.Hmaster_data); end
        checks++; if (bus.Hwdata !== 32'hDEAD0002) begin errors++; $display("FAIL ho_m2_data: got %h expected dead0002", bus.Hwdata); end
        cyc();
    endtask

    task automatic test_grant_mismatch();
        bus.Hmaster = 2'd3;
        bus.Hgrant  = 4'b0001;
        set_m(3, 32'h5000, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 32'h0);
        #1;
        checks++; if (bus.Htrans !== 2'b00) begin errors++; $display("FAIL gm_htrans: got %b expected 00", bus.Htrans); end
        checks++; if (bus.Haddr !== 32'h5000) begin errors++; $display("FAIL gm_haddr: got %h expected 5000", bus.Haddr); end
        bus.Hgrant = 4'b1000;
        #1;
        checks++; if (bus.Htrans !== 2'b10) begin errors++; $display("FAIL gm_granted_htrans: got %b expected 10", bus.Htrans); end
        set_m(3, 32'h5000, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 32'h0);
        cyc();
    endtask

    task automatic test_error();
        set_own(1);
        set_m(1, 32'h4000, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE, 32'h11111111);
        bus.Hready = 1'b1;
        bus.Hresp  = HRESP_OKAY;
        cyc();
        set_m(1, 32'h4000, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 32'h11111111);
        set_own(2);
        set_m(2, 32'h6000, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE, 32'h22222222);
        bus.Hresp  = HRESP_ERROR;
        bus.Hready = 1'b0;
        #1;
        checks++; if (bus.Hcancel !== 1'b0) begin errors++; $display("FAIL errA_hcancel: got %b expected 0", bus.Hcancel); end
        checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL errA_count: got %0d expected 0", bus.err_count); end
        checks++; if (bus.Htrans !== 2'b10) begin errors++; $display("FAIL errA_htrans: got %b expected 10", bus.Htrans); end
        cyc();
        bus.Hready = 1'b1;
        #1;
        checks++; if (bus.Hcancel !== 1'b1) begin errors++; $display("FAIL errB_hcancel: got %b expected 1", bus.Hcancel); end
        checks++; if (bus.Htrans !== 2'b00) begin errors++; $display("FAIL errB_htrans: got %b expected 00", bus.Htrans); end
        checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL errB_count: got %0d expected 1", bus.err_count); end
        cyc();
        bus.Hresp = HRESP_OKAY;
        #1;
        checks++; if (bus.Hcancel !== 1'b0) begin errors++; $display("FAIL errdone_hcancel: got %b expected 0", bus.Hcancel); end
        checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL errdone_count: got %0d expected 1", bus.err_count); end
        checks++; if (bus.Hmaster_data !== 2'd2) begin errors++; $display("FAIL errdone_owner: got %0d expected 2", bus.Hmaster_data); end
        checks++; if (bus.Hwdata !== 32'h0) begin errors++; $display("FAIL errdone_hwdata: got %h expected 0", bus.Hwdata); end
        checks++; if (bus.Htrans !== 2'b10) begin errors++; $display("FAIL errdone_htrans: got %b expected 10", bus.Htrans); end
        cyc();
    endtask

    task automatic test_protocol_violation();
        set_m(2, 32'h6000, HTRANS_IDLE, 1'b1, HBURST_SINGLE, 32'h22222222);
        bus.Hresp  = HRESP_ERROR;
        bus.Hready = 1'b0;
        cyc();
        bus.Hresp = HRESP_OKAY;
        #1;
        checks++; if (bus.Hcancel !== 1'b1) begin errors++; $display("FAIL pv_hcancel_set: got %b expected 1", bus.Hcancel); end
        cyc();
        checks++; if (bus.Hcancel !== 1'b0) begin errors++; $display("FAIL pv_hcancel_clr: got %b expected 0", bus.Hcancel); end
        checks++; if (bus.err_count !== 8'd2) begin errors++; $display("FAIL pv_count: got %0d expected 2", bus.err_count); end
        bus.Hready = 1'b1;
        cyc();
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 260; n++) begin
            set_own(0);
            set_m(0, 32'h7000, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE, 32'h0);
            bus.Hresp  = HRESP_OKAY;
            bus.Hready = 1'b1;
            cyc();
            bus.Hresp  = HRESP_ERROR;
            bus.Hready = 1'b0;
            cyc();
            bus.Hready = 1'b1;
            cyc();
            if (n == 249) begin
                checks++; if (bus.err_count !== 8'd252) begin errors++; $display("FAIL sat_mid_count: got %0d expected 252", bus.err_count); end
            end
        end
        bus.Hresp = HRESP_OKAY;
        #1;
        checks++; if (bus.err_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d expected 255", bus.err_count); end
    endtask

    task automatic test_async_reset();
        set_m(0, 32'h7000, HTRANS_IDLE, 1'b0, HBURST_SINGLE, 32'h0);
        set_own(2);
        set_m(2, 32'h8000, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE, 32'h33333333);
        bus.Hresp  = HRESP_OKAY;
        bus.Hready = 1'b1;
        cyc();
        bus.Hresp  = HRESP_ERROR;
        bus.Hready = 1'b0;
        cyc();
        checks++; if (bus.Hcancel !== 1'b1) begin errors++; $display("FAIL ar_pre_hcancel: got %b expected 1", bus.Hcancel); end
        checks++; if (bus.Hmaster_data !== 2'd2) begin errors++; $display("FAIL ar_pre_owner: got %0d expected 2", bus.Hmaster_data); end
        #1 Hresetn = 1'b0;
        #1;
        checks++; if (bus.Hcancel !== 1'b0) begin errors++; $display("FAIL ar_hcancel: got %b expected 0", bus.Hcancel); end
        checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL ar_count: got %0d expected 0", bus.err_count); end
        checks++; if (bus.Hmaster_data !== 2'd0) begin errors++; $display("FAIL ar_owner: got %0d expected 0", bus.Hmaster_data); end
        checks++; if (bus.Htrans !== 2'b00) begin errors++; $display("FAIL ar_htrans: got %b expected 00", bus.Htrans); end
        checks++; if (bus.Hwdata !== 32'h0) begin errors++; $display("FAIL ar_hwdata: got %h expected 0", bus.Hwdata); end
        bus.Hresp = HRESP_OKAY;
        cyc();
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_handover();
        test_grant_mismatch();
        test_error();
        test_protocol_violation();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
